mem_responder: RTL and testbench

Memory-side responder for the CPU's single-master RAM bus (address/data/wren out, q in). It provides a synchronous word RAM with one-cycle read latency and a small memory-mapped I/O page: an LED register, a free-running cycle counter, and a console output FIFO with a valid/ready drain port. It sits directly opposite the CPU core at top level.

---
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: synchronous word RAM, LED/CYCLE registers and an optional console FIFO.
// Console FIFO, TXDATA and TXSTAT are built only when MEM_RESPONDER_CONSOLE_EN is defined.
module mem_responder #(
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic [15:0] address,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q,
   output logic [7:0]  led,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int unsigned RAM_WORDS = 1 << ADDR_W;

   logic [31:0] r_mem [RAM_WORDS];
   logic [31:0] r_q;
   logic [7:0]  r_led;
   logic [31:0] r_cycle;
   logic [31:0] w_rdata;
   logic        w_io;
   logic        w_ram;
   logic [7:0]  w_off;

   assign w_io  = (address[15:8] == 8'hFF);
   assign w_ram = !w_io && ((address >> ADDR_W) == 16'd0);
   assign w_off = address[7:0];

   always_ff @(posedge clk) begin
      if (nreset && wren && w_ram) begin
         r_mem[address[ADDR_W-1:0]] <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_led   <= '0;
         r_cycle <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (wren && w_io && (w_off == 8'h00)) begin
            r_led <= data[7:0];
         end
      end
   end

`ifdef MEM_RESPONDER_CONSOLE_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   logic          r_ovf;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_ovf_set;
   logic          w_stat_rd;
   logic [8:0]    w_cnt9;
   logic [31:0]   w_stat;

   // Count saturates at FIFO_DEPTH (a power of two), so the MSB alone means full.
   assign w_full    = r_count[PW];
   assign w_push    = nreset && wren && w_io && (w_off == 8'h02);
   assign w_pop     = nreset && tx_valid && tx_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && w_full && !w_pop;
   assign w_stat_rd = w_io && (w_off == 8'h03);
   assign w_cnt9    = 9'(r_count);
   assign w_stat    = {16'h0, w_cnt9[7:0], 5'h0, r_ovf, (r_count == '0), w_full};

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_fifo[r_wptr] <= data[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push_ok && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push_ok && w_pop) begin
            r_count <= r_count - 1'b1;
         end
         // A new overflow in the same cycle as a status read must not be lost.
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign tx_valid = (r_count != '0);
   assign tx_data  = r_fifo[r_rptr];
`else
   logic w_unused_tx_ready;

   assign w_unused_tx_ready = tx_ready;
   assign tx_valid          = 1'b0;
   assign tx_data           = '0;
`endif

   always_comb begin
      w_rdata = '0;
      if (w_io) begin
         case (w_off)
            8'h00:   w_rdata = {24'h0, r_led};
            8'h01:   w_rdata = r_cycle;
`ifdef MEM_RESPONDER_CONSOLE_EN
            8'h03:   w_rdata = w_stat;
`endif
            default: w_rdata = '0;
         endcase
      end else if (w_ram) begin
         w_rdata = r_mem[address[ADDR_W-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_q <= '0;
      end else begin
         r_q <= w_rdata;
      end
   end

   assign q   = r_q;
   assign led = r_led;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; FIFO checks follow MEM_RESPONDER_CONSOLE_EN.
module tb_mem_responder;

   logic        clk;
   logic        nreset;
   logic [15:0] address;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q;
   logic [7:0]  led;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_cmp;
   int n_err;

   mem_responder #(.ADDR_W(12), .FIFO_DEPTH(16)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .address  (address),
      .data     (data),
      .wren     (wren),
      .q        (q),
      .led      (led),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Present one bus cycle and return #1 after the edge that consumes it.
   task automatic cyc(input logic [15:0] a, input logic [31:0] d, input logic we);
      address = a;
      data    = d;
      wren    = we;
      @(posedge clk);
      #1;
      wren    = 1'b0;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      nreset   = 1'b0;
      address  = '0;
      data     = '0;
      wren     = 1'b0;
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", q, 32'h0);
      chk("rst_led", {24'h0, led}, 32'h0);
      chk("rst_txv", {31'h0, tx_valid}, 32'h0);

      nreset = 1'b1;
      cyc(16'hFF01, 32'h0, 1'b0);
      chk("cycle_first", q, 32'd0);
      cyc(16'hFF01, 32'h0, 1'b0);
      chk("cycle_second", q, 32'd1);
      cyc(16'h0000, 32'h0, 1'b0);
      cyc(16'h0000, 32'h0, 1'b0);
      cyc(16'hFF01, 32'h0, 1'b0);
      chk("cycle_plus3", q, 32'd4);

      cyc(16'h0010, 32'hDEADBEEF, 1'b1);
      cyc(16'h0010, 32'h0, 1'b0);
      chk("ram_rd", q, 32'hDEADBEEF);
      cyc(16'h2000, 32'h0, 1'b0);
      chk("ram_oor", q, 32'h0);
      cyc(16'h0000, 32'h11111111, 1'b1);
      cyc(16'h2000, 32'h22222222, 1'b1);
      cyc(16'h0000, 32'h0, 1'b0);
      chk("ram_oor_wr", q, 32'h11111111);
      cyc(16'h0FFF, 32'hCAFEF00D, 1'b1);
      cyc(16'h0FFF, 32'h0, 1'b0);
      chk("ram_top", q, 32'hCAFEF00D);
      cyc(16'h1000, 32'h0, 1'b0);
      chk("ram_edge", q, 32'h0);

      cyc(16'h0005, 32'd1, 1'b1);
      cyc(16'h0005, 32'd2, 1'b1);
      chk("rdw_old", q, 32'd1);
      cyc(16'h0005, 32'h0, 1'b0);
      chk("rdw_new", q, 32'd2);

      cyc(16'hFF00, 32'h123456A5, 1'b1);
      chk("led_wr", {24'h0, led}, 32'h000000A5);
      cyc(16'hFF00, 32'h0, 1'b0);
      chk("led_rd", q, 32'h000000A5);

      nreset = 1'b0;
      cyc(16'hFF00, 32'h00000077, 1'b1);
      chk("mid_rst_led", {24'h0, led}, 32'h0);
      chk("mid_rst_q", q, 32'h0);
      cyc(16'h0005, 32'h99, 1'b1);
      nreset = 1'b1;
      cyc(16'hFF01, 32'h0, 1'b0);
      chk("mid_rst_cycle", q, 32'd0);
      cyc(16'h0005, 32'h0, 1'b0);
      chk("rst_wr_ignored", q, 32'd2);

`ifdef MEM_RESPONDER_CONSOLE_EN
      cyc(16'hFF03, 32'h0, 1'b0);
      chk("stat_empty", q, 32'h00000002);
      chk("txv_before_push", {31'h0, tx_valid}, 32'h0);
      for (int i = 0; i < 17; i++) begin
         cyc(16'hFF02, 32'(i), 1'b1);
         if (i == 0) begin
            chk("push_visible", {31'h0, tx_valid}, 32'h1);
            chk("push_head", {24'h0, tx_data}, 32'h0);
         end
      end
      cyc(16'hFF03, 32'h0, 1'b0);
      chk("stat_ovf", q, 32'h00001005);
      cyc(16'hFF03, 32'h0, 1'b0);
      chk("stat_ovf_clr", q, 32'h00001001);
      address  = 16'h0000;
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_valid", {31'h0, tx_valid}, 32'h1);
         chk("drain_data", {24'h0, tx_data}, 32'(i));
         @(posedge clk);
         #1;
      end
      chk("drain_empty", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      for (int i = 0; i < 16; i++) begin
         cyc(16'hFF02, 32'h30 + 32'(i), 1'b1);
      end
      tx_ready = 1'b1;
      cyc(16'hFF02, 32'hAA, 1'b1);
      tx_ready = 1'b0;
      cyc(16'hFF03, 32'h0, 1'b0);
      chk("stat_pushpop", q, 32'h00001001);
      address  = 16'h0000;
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("pp_valid", {31'h0, tx_valid}, 32'h1);
         chk("pp_data", {24'h0, tx_data}, (i == 15) ? 32'hAA : 32'h31 + 32'(i));
         @(posedge clk);
         #1;
      end
      chk("pp_empty", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
`else
      tx_ready = 1'b1;
      cyc(16'hFF02, 32'h55, 1'b1);
      chk("off_txv", {31'h0, tx_valid}, 32'h0);
      chk("off_txd", {24'h0, tx_data}, 32'h0);
      cyc(16'hFF03, 32'h0, 1'b0);
      chk("off_stat", q, 32'h0);
      chk("off_txv2", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
